hop_mode_ctrl: RTL and testbench
================================

HOP_MODE_CTRL -- requirements
Module: hop_mode_ctrl

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk_6M  in  1  system clock, 6 MHz
- rstz  in  1  reset, asynchronous, active-low
- m_tslot_p  in  1  one-cycle pulse at each 625 us slot boundary
- start_page, start_inquiry, start_pscan, start_iscan  in  1 each  one-cycle start commands
- id_rx_p  in  1  ID packet received (page/inquiry/scan response)
- fhs_done_p  in  1  FHS packet sent or received
- conn_ok_p  in  1  first connection-state POLL/NULL exchange done
- abort  in  1  level, return to IDLE
- regi_Npage  in  4  train repetitions per A/B switch, 0 treated as 1
- regi_timeout  in  16  PAGE/INQ/scan timeout in slots, 0 = never
- regi_interlace_en  in  1  interlaced scan enable
- ps, gips, is, giis, page, inquiry, mpr, spr, ir, conns  out  1 each  one-hot mode selects, all 0 in IDLE
- Atrain  out  1  1 = A train, 0 = B train
- pageAB_2Npage_count  out  4  completed A/B switches, saturates at 15
- prm_clock_frozen, prs_clock_frozen  out  1 each  freeze CLKE / CLKN captures
- counter_isFHS  out  5  FHS responses since inquiry scan start, mod 32
- timeout_p  out  1  one-cycle timeout pulse
- busy  out  1  state != IDLE

Function
REQ-002 SHALL implement the states IDLE, PSCAN, GIPSCAN, ISCAN, GIISCAN, PAGE, INQ, MPR, SPR, IR and CONN, all registered; each mode output SHALL equal its state decode.
REQ-003 In IDLE, starts SHALL be accepted with priority start_page > start_inquiry > start_pscan > start_iscan; the resulting transition SHALL occur on the next clock. Starts outside IDLE SHALL be ignored.
REQ-004 PAGE: id_rx_p -> MPR. MPR: fhs_done_p -> CONN. PSCAN/GIPSCAN: id_rx_p -> SPR. SPR: fhs_done_p -> CONN. INQ: fhs_done_p -> INQ, with no state change. ISCAN/GIISCAN: id_rx_p -> IR. IR: fhs_done_p -> ISCAN, and counter_isFHS increments in the same edge.
REQ-005 CONN SHALL exit only on abort; conn_ok_p SHALL have no state effect and SHALL be reserved for status.
REQ-006 Slot counter (16 bit) SHALL clear on every state change and increment on m_tslot_p.
- PAGE/INQ/scan states: when the counter reaches regi_timeout (nonzero), SHALL pulse timeout_p for one cycle and go to IDLE.
- MPR/SPR/IR: after 8 slots without the exit event, SHALL pulse timeout_p and return to PAGE/PSCAN/ISCAN respectively.
REQ-007 Priority per clock: abort > timeout > protocol event. A simultaneous event and timeout SHALL take the timeout path.
REQ-008 Train sequencing, active in PAGE and INQ only:
- A 4-bit train-slot counter SHALL count m_tslot_p 0..15.
- At each wrap, a repetition counter SHALL increment.
- When the repetition counter reaches max(regi_Npage,1): Atrain SHALL toggle, the repetition counter SHALL clear, and pageAB_2Npage_count SHALL increment, saturating at 15.
- Entry into PAGE/INQ from IDLE SHALL set Atrain=1 and clear all three counters.
- MPR return to PAGE SHALL preserve them.
REQ-009 prm_clock_frozen SHALL be 1 exactly while in MPR; prs_clock_frozen SHALL be 1 exactly while in SPR. Both SHALL assert on the same edge as the state entry, so the frozen value is the CLKE/CLKN of the cycle before.
REQ-010 counter_isFHS SHALL clear on entry to ISCAN/GIISCAN from IDLE and wrap from 31 to 0.
REQ-011 With interlacing active, a scan SHALL alternate PSCAN<->GIPSCAN (ISCAN<->GIISCAN) every 16 slots. The slot counter SHALL NOT clear on this alternation, so the timeout spans the whole scan. A response in either state SHALL behave identically.
REQ-012 Exactly zero or one mode output SHALL be high in every cycle.

Reset
REQ-013 On rstz low, SHALL enter IDLE with every mode output 0, Atrain=1, and pageAB_2Npage_count, counter_isFHS, timeout_p, both freeze outputs, busy and all internal counters 0.
REQ-014 On abort, SHALL apply the same values as reset, synchronously on the next edge, except that counter_isFHS is held.

Configuration
REQ-015 Macro HOP_INTERLACE_EN:
- Defined: REQ-011 SHALL apply when regi_interlace_en=1.
- Undefined: GIPSCAN/GIISCAN SHALL be absent, gips and giis SHALL be tied 0, and regi_interlace_en SHALL be ignored.

Verification
REQ-016 regi_Npage=2, start_page, 80 slots -> Atrain toggles at slots 32 and 64; pageAB_2Npage_count=2 at slot 64.
REQ-017 PAGE, id_rx_p at slot 5 -> next cycle mpr=1 and prm_clock_frozen=1; fhs_done_p -> conns=1 and prm_clock_frozen=0.
REQ-018 MPR with no fhs_done_p for 8 slots -> timeout_p pulse, page=1, Atrain and counters unchanged.
REQ-019 ISCAN, three id_rx_p/fhs_done_p pairs -> counter_isFHS=3, is=1. From 31, one more pair -> counter_isFHS=0.
REQ-020 regi_timeout=10, start_inquiry -> timeout_p at slot 10, IDLE. Same with abort at slot 4 -> IDLE at slot 4, no timeout_p.
REQ-021 HOP_INTERLACE_EN defined, regi_interlace_en=1, start_pscan -> ps for slots 0-15, gips for slots 16-31, ps again at slot 32. Macro undefined -> ps throughout.

Source files
------------

// File: rtl/hop_mode_ctrl_if.sv
// Command/status bundle between the link controller and hop_mode_ctrl.
// Latency: none (wires only); the master drives commands, the slave drives mode selects.
// Backpressure: none; every command is a single-cycle pulse or a level.
interface hop_mode_ctrl_if;
   logic        m_tslot_p;
   logic        start_page;
   logic        start_inquiry;
   logic        start_pscan;
   logic        start_iscan;
   logic        id_rx_p;
   logic        fhs_done_p;
   logic        conn_ok_p;
   logic        abort;
   logic [3:0]  regi_Npage;
   logic [15:0] regi_timeout;
   logic        regi_interlace_en;

   logic        ps;
   logic        gips;
   logic        is;
   logic        giis;
   logic        page;
   logic        inquiry;
   logic        mpr;
   logic        spr;
   logic        ir;
   logic        conns;
   logic        Atrain;
   logic [3:0]  pageAB_2Npage_count;
   logic        prm_clock_frozen;
   logic        prs_clock_frozen;
   logic [4:0]  counter_isFHS;
   logic        timeout_p;
   logic        busy;

   modport master (
      output m_tslot_p, start_page, start_inquiry, start_pscan, start_iscan,
             id_rx_p, fhs_done_p, conn_ok_p, abort,
             regi_Npage, regi_timeout, regi_interlace_en,
      input  ps, gips, is, giis, page, inquiry, mpr, spr, ir, conns,
             Atrain, pageAB_2Npage_count, prm_clock_frozen, prs_clock_frozen,
             counter_isFHS, timeout_p, busy
   );

   modport slave (
      input  m_tslot_p, start_page, start_inquiry, start_pscan, start_iscan,
             id_rx_p, fhs_done_p, conn_ok_p, abort,
             regi_Npage, regi_timeout, regi_interlace_en,
      output ps, gips, is, giis, page, inquiry, mpr, spr, ir, conns,
             Atrain, pageAB_2Npage_count, prm_clock_frozen, prs_clock_frozen,
             counter_isFHS, timeout_p, busy
   );
endinterface

// File: rtl/hop_mode_ctrl.sv
// Baseband hop-mode FSM: page/inquiry/scan/response/connection mode selects, A/B train sequencing.
// Latency: every command or event acts on the next clk_6M edge; all outputs decode registered state.
// Backpressure: none; priority abort > timeout > protocol event. Option macro: HOP_INTERLACE_EN.
module hop_mode_ctrl (
   input  logic              clk_6M,
   input  logic              rstz,
   hop_mode_ctrl_if.slave    bus
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] PSCAN   = 4'd1;
   localparam logic [3:0] GIPSCAN = 4'd2;
   localparam logic [3:0] ISCAN   = 4'd3;
   localparam logic [3:0] GIISCAN = 4'd4;
   localparam logic [3:0] PAGE    = 4'd5;
   localparam logic [3:0] INQ     = 4'd6;
   localparam logic [3:0] MPR     = 4'd7;
   localparam logic [3:0] SPR     = 4'd8;
   localparam logic [3:0] IR      = 4'd9;
   localparam logic [3:0] CONN    = 4'd10;

   // Response states give up after this many slots without their exit event.
   localparam logic [15:0] RESP_SLOTS = 16'd8;

   logic [3:0]  state_q,  state_d;
   logic [15:0] slot_q,   slot_d;
   logic [3:0]  train_q,  train_d;
   logic [3:0]  rep_q,    rep_d;
   logic        atrain_q, atrain_d;
   logic [3:0]  ab_q,     ab_d;
   logic [4:0]  isfhs_q,  isfhs_d;
   logic        tmo_q,    tmo_d;

   logic [15:0] slot_inc;
   logic [15:0] limit;
   logic        tmo_hit;
   logic        alt;
   logic [3:0]  npage_eff;

   // Slot count after this edge, the timeout limit for the current state and its hit condition.
   always_comb begin
      slot_inc  = slot_q + 16'(bus.m_tslot_p);
      npage_eff = (bus.regi_Npage == 4'd0) ? 4'd1 : bus.regi_Npage;
      case (state_q)
         PSCAN, GIPSCAN, ISCAN, GIISCAN, PAGE, INQ: limit = bus.regi_timeout;
         MPR, SPR, IR:                             limit = RESP_SLOTS;
         default:                                  limit = 16'd0;
      endcase
      tmo_hit = bus.m_tslot_p && (limit != 16'd0) && (slot_inc == limit);
   end

   // Next-state, counters and timeout pulse; abort first, then timeout, then protocol events.
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_inc;
      train_d  = train_q;
      rep_d    = rep_q;
      atrain_d = atrain_q;
      ab_d     = ab_q;
      isfhs_d  = isfhs_q;
      tmo_d    = 1'b0;
      alt      = 1'b0;

      if (bus.abort) begin
         state_d  = IDLE;
         slot_d   = 16'd0;
         train_d  = 4'd0;
         rep_d    = 4'd0;
         atrain_d = 1'b1;
         ab_d     = 4'd0;
      end else begin
         // Train slots run only while paging or inquiring; MPR leaves them parked.
         if ((state_q == PAGE || state_q == INQ) && bus.m_tslot_p) begin
            train_d = train_q + 4'd1;
            if (train_q == 4'd15) begin
               if (({1'b0, rep_q} + 5'd1) >= {1'b0, npage_eff}) begin
                  atrain_d = ~atrain_q;
                  rep_d    = 4'd0;
                  if (ab_q != 4'd15) ab_d = ab_q + 4'd1;
               end else begin
                  rep_d = rep_q + 4'd1;
               end
            end
         end

         if (tmo_hit) begin
            tmo_d = 1'b1;
            case (state_q)
               MPR:     state_d = PAGE;
               SPR:     state_d = PSCAN;
               IR:      state_d = ISCAN;
               default: state_d = IDLE;
            endcase
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start_page || bus.start_inquiry) begin
                     state_d  = bus.start_page ? PAGE : INQ;
                     train_d  = 4'd0;
                     rep_d    = 4'd0;
                     atrain_d = 1'b1;
                     ab_d     = 4'd0;
                  end else if (bus.start_pscan) begin
                     state_d = PSCAN;
                  end else if (bus.start_iscan) begin
                     state_d = ISCAN;
                     isfhs_d = 5'd0;
                  end
               end
               PAGE: if (bus.id_rx_p) state_d = MPR;
               PSCAN, GIPSCAN: begin
                  if (bus.id_rx_p) begin
                     state_d = SPR;
                  end
`ifdef HOP_INTERLACE_EN
                  else if (bus.regi_interlace_en && bus.m_tslot_p && slot_inc[3:0] == 4'd0) begin
                     state_d = (state_q == PSCAN) ? GIPSCAN : PSCAN;
                     alt     = 1'b1;
                  end
`endif
               end
               ISCAN, GIISCAN: begin
                  if (bus.id_rx_p) begin
                     state_d = IR;
                  end
`ifdef HOP_INTERLACE_EN
                  else if (bus.regi_interlace_en && bus.m_tslot_p && slot_inc[3:0] == 4'd0) begin
                     state_d = (state_q == ISCAN) ? GIISCAN : ISCAN;
                     alt     = 1'b1;
                  end
`endif
               end
               MPR, SPR: if (bus.fhs_done_p) state_d = CONN;
               IR: begin
                  if (bus.fhs_done_p) begin
                     state_d = ISCAN;
                     isfhs_d = isfhs_q + 5'd1;
                  end
               end
               // INQ keeps inquiring after each FHS; CONN leaves only on abort.
               default: state_d = state_q;
            endcase
         end

         // Interlace alternation keeps the count so the timeout spans the whole scan.
         if (state_d != state_q && !alt) slot_d = 16'd0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         state_q  <= IDLE;
         slot_q   <= 16'd0;
         train_q  <= 4'd0;
         rep_q    <= 4'd0;
         atrain_q <= 1'b1;
         ab_q     <= 4'd0;
         isfhs_q  <= 5'd0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         train_q  <= train_d;
         rep_q    <= rep_d;
         atrain_q <= atrain_d;
         ab_q     <= ab_d;
         isfhs_q  <= isfhs_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.ps      = (state_q == PSCAN);
   assign bus.is      = (state_q == ISCAN);
`ifdef HOP_INTERLACE_EN
   assign bus.gips    = (state_q == GIPSCAN);
   assign bus.giis    = (state_q == GIISCAN);
`else
   assign bus.gips    = 1'b0;
   assign bus.giis    = 1'b0;
`endif
   assign bus.page    = (state_q == PAGE);
   assign bus.inquiry = (state_q == INQ);
   assign bus.mpr     = (state_q == MPR);
   assign bus.spr     = (state_q == SPR);
   assign bus.ir      = (state_q == IR);
   assign bus.conns   = (state_q == CONN);

   // Freeze flags follow the registered state, so they capture the clock of the cycle before entry.
   assign bus.prm_clock_frozen    = (state_q == MPR);
   assign bus.prs_clock_frozen    = (state_q == SPR);
   assign bus.Atrain              = atrain_q;
   assign bus.pageAB_2Npage_count = ab_q;
   assign bus.counter_isFHS       = isfhs_q;
   assign bus.timeout_p           = tmo_q;
   assign bus.busy                = (state_q != IDLE);

endmodule

// File: tb/tb_hop_mode_ctrl.sv
// Directed bench for hop_mode_ctrl: reset, start priority, train sequencing, response timeouts,
// inquiry-scan FHS counter, scan timeouts/abort and interlaced scan (follows HOP_INTERLACE_EN).
// Inputs change and outputs are sampled on the falling edge.
module tb_hop_mode_ctrl;

   localparam logic [9:0] M_NONE = 10'h000;
   localparam logic [9:0] M_PS   = 10'h200;
   localparam logic [9:0] M_GIPS = 10'h100;
   localparam logic [9:0] M_IS   = 10'h080;
   localparam logic [9:0] M_PAGE = 10'h020;
   localparam logic [9:0] M_INQ  = 10'h010;
   localparam logic [9:0] M_MPR  = 10'h008;
   localparam logic [9:0] M_SPR  = 10'h004;
   localparam logic [9:0] M_IR   = 10'h002;
   localparam logic [9:0] M_CONN = 10'h001;

   logic clk = 1'b0;
   logic rstz;
   int   checks = 0;
   int   failures = 0;
   logic [9:0] modes;

   always #5 clk = ~clk;

   hop_mode_ctrl_if bus ();

   hop_mode_ctrl dut (
      .clk_6M (clk),
      .rstz   (rstz),
      .bus    (bus)
   );

   assign modes = {bus.ps, bus.gips, bus.is, bus.giis, bus.page, bus.inquiry,
                   bus.mpr, bus.spr, bus.ir, bus.conns};

   // At most one mode select may be high in any cycle.
   always @(negedge clk) begin
      if (rstz === 1'b1) begin
         checks++;
         if ($countones(modes) > 1) begin
            failures++;
            $display("FAIL onehot: modes=%b at %0t", modes, $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic slot();
      bus.m_tslot_p = 1'b1;
      tick();
      bus.m_tslot_p = 1'b0;
      tick();
   endtask

   task automatic do_abort();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic test_reset();
      bus.m_tslot_p = 0; bus.start_page = 0; bus.start_inquiry = 0; bus.start_pscan = 0;
      bus.start_iscan = 0; bus.id_rx_p = 0; bus.fhs_done_p = 0; bus.conn_ok_p = 0;
      bus.abort = 0; bus.regi_Npage = 4'd1; bus.regi_timeout = 16'd0; bus.regi_interlace_en = 0;
      rstz = 1'b0;
      #12;
      checks++; if (modes !== M_NONE) begin failures++; $display("FAIL reset_modes: got %b want %b", modes, M_NONE); end
      checks++; if (bus.Atrain !== 1'b1) begin failures++; $display("FAIL reset_atrain: got %b want 1", bus.Atrain); end
      checks++; if (bus.pageAB_2Npage_count !== 4'd0) begin failures++; $display("FAIL reset_abcnt: got %0d want 0", bus.pageAB_2Npage_count); end
      checks++; if (bus.counter_isFHS !== 5'd0) begin failures++; $display("FAIL reset_isfhs: got %0d want 0", bus.counter_isFHS); end
      checks++; if ({bus.timeout_p, bus.busy, bus.prm_clock_frozen, bus.prs_clock_frozen} !== 4'b0000) begin
         failures++; $display("FAIL reset_flags: got %b want 0000", {bus.timeout_p, bus.busy, bus.prm_clock_frozen, bus.prs_clock_frozen});
      end
      @(negedge clk);
      rstz = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_priority();
      bus.start_page = 1; bus.start_inquiry = 1; bus.start_pscan = 1;
      tick();
      bus.start_page = 0; bus.start_inquiry = 0; bus.start_pscan = 0;
      checks++; if (modes !== M_PAGE) begin failures++; $display("FAIL prio_page: got %b want %b", modes, M_PAGE); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL prio_busy: got %b want 1", bus.busy); end
      bus.start_inquiry = 1;
      tick();
      bus.start_inquiry = 0;
      checks++; if (modes !== M_PAGE) begin failures++; $display("FAIL start_ignored: got %b want %b", modes, M_PAGE); end
      do_abort();
      bus.start_inquiry = 1; bus.start_iscan = 1;
      tick();
      bus.start_inquiry = 0; bus.start_iscan = 0;
      checks++; if (modes !== M_INQ) begin failures++; $display("FAIL prio_inq: got %b want %b", modes, M_INQ); end
      do_abort();
      bus.start_pscan = 1; bus.start_iscan = 1;
      tick();
      bus.start_pscan = 0; bus.start_iscan = 0;
      checks++; if (modes !== M_PS) begin failures++; $display("FAIL prio_pscan: got %b want %b", modes, M_PS); end
      do_abort();
      bus.start_page = 1; bus.abort = 1;
      tick();
      bus.start_page = 0; bus.abort = 0;
      checks++; if (modes !== M_NONE) begin failures++; $display("FAIL abort_over_start: got %b want %b", modes, M_NONE); end
   endtask

   task automatic test_train();
      bus.regi_Npage = 4'd2; bus.regi_timeout = 16'd0;
      bus.start_page = 1;
      tick();
      bus.start_page = 0;
      for (int s = 1; s <= 80; s++) begin
         slot();
         checks++;
         if (bus.Atrain !== (((s / 32) % 2) == 0) || bus.pageAB_2Npage_count !== 4'(s / 32)) begin
            failures++;
            $display("FAIL train_slot%0d: Atrain=%b cnt=%0d want Atrain=%b cnt=%0d", s, bus.Atrain,
                     bus.pageAB_2Npage_count, ((s / 32) % 2) == 0, s / 32);
         end
      end
      checks++; if (modes !== M_PAGE) begin failures++; $display("FAIL train_still_page: got %b want %b", modes, M_PAGE); end
      do_abort();
   endtask

   task automatic test_page_mpr_conn();
      bus.regi_Npage = 4'd1;
      bus.start_page = 1;
      tick();
      bus.start_page = 0;
      repeat (5) slot();
      bus.id_rx_p = 1;
      tick();
      bus.id_rx_p = 0;
      checks++; if (modes !== M_MPR) begin failures++; $display("FAIL page_to_mpr: got %b want %b", modes, M_MPR); end
      checks++; if ({bus.prm_clock_frozen, bus.prs_clock_frozen} !== 2'b10) begin
         failures++; $display("FAIL mpr_frozen: got %b want 10", {bus.prm_clock_frozen, bus.prs_clock_frozen});
      end
      bus.fhs_done_p = 1;
      tick();
      bus.fhs_done_p = 0;
      checks++; if (modes !== M_CONN) begin failures++; $display("FAIL mpr_to_conn: got %b want %b", modes, M_CONN); end
      checks++; if (bus.prm_clock_frozen !== 1'b0) begin failures++; $display("FAIL conn_unfrozen: got %b want 0", bus.prm_clock_frozen); end
      bus.conn_ok_p = 1;
      tick();
      bus.conn_ok_p = 0;
      repeat (10) slot();
      checks++; if (modes !== M_CONN) begin failures++; $display("FAIL conn_held: got %b want %b", modes, M_CONN); end
      do_abort();
      checks++; if (modes !== M_NONE || bus.busy !== 1'b0) begin failures++; $display("FAIL conn_abort: modes=%b busy=%b want 0", modes, bus.busy); end
   endtask

   task automatic test_mpr_timeout();
      bus.regi_Npage = 4'd1;
      bus.start_page = 1;
      tick();
      bus.start_page = 0;
      repeat (20) slot();
      checks++; if (bus.Atrain !== 1'b0 || bus.pageAB_2Npage_count !== 4'd1) begin
         failures++; $display("FAIL pre_mpr_train: Atrain=%b cnt=%0d want 0/1", bus.Atrain, bus.pageAB_2Npage_count);
      end
      bus.id_rx_p = 1;
      tick();
      bus.id_rx_p = 0;
      repeat (7) slot();
      checks++; if (modes !== M_MPR || bus.timeout_p !== 1'b0) begin
         failures++; $display("FAIL mpr_7slots: modes=%b tmo=%b want %b/0", modes, bus.timeout_p, M_MPR);
      end
      // Eighth slot coincides with fhs_done_p: the timeout path wins.
      bus.m_tslot_p = 1; bus.fhs_done_p = 1;
      tick();
      bus.m_tslot_p = 0; bus.fhs_done_p = 0;
      checks++; if (bus.timeout_p !== 1'b1) begin failures++; $display("FAIL mpr_tmo_pulse: got %b want 1", bus.timeout_p); end
      checks++; if (modes !== M_PAGE) begin failures++; $display("FAIL mpr_tmo_page: got %b want %b", modes, M_PAGE); end
      checks++; if (bus.Atrain !== 1'b0 || bus.pageAB_2Npage_count !== 4'd1 || bus.prm_clock_frozen !== 1'b0) begin
         failures++; $display("FAIL mpr_tmo_kept: Atrain=%b cnt=%0d prm=%b want 0/1/0", bus.Atrain, bus.pageAB_2Npage_count, bus.prm_clock_frozen);
      end
      tick();
      checks++; if (bus.timeout_p !== 1'b0) begin failures++; $display("FAIL mpr_tmo_one_cycle: got %b want 0", bus.timeout_p); end
      // Train slot resumes at 4, so the next toggle is 12 slots away.
      repeat (11) slot();
      checks++; if (bus.Atrain !== 1'b0) begin failures++; $display("FAIL resume_11: Atrain=%b want 0", bus.Atrain); end
      slot();
      checks++; if (bus.Atrain !== 1'b1 || bus.pageAB_2Npage_count !== 4'd2) begin
         failures++; $display("FAIL resume_12: Atrain=%b cnt=%0d want 1/2", bus.Atrain, bus.pageAB_2Npage_count);
      end
      do_abort();
      bus.start_pscan = 1;
      tick();
      bus.start_pscan = 0;
      bus.id_rx_p = 1;
      tick();
      bus.id_rx_p = 0;
      checks++; if (modes !== M_SPR || {bus.prm_clock_frozen, bus.prs_clock_frozen} !== 2'b01) begin
         failures++; $display("FAIL pscan_to_spr: modes=%b frz=%b want %b/01", modes, {bus.prm_clock_frozen, bus.prs_clock_frozen}, M_SPR);
      end
      bus.fhs_done_p = 1;
      tick();
      bus.fhs_done_p = 0;
      checks++; if (modes !== M_CONN || bus.prs_clock_frozen !== 1'b0) begin
         failures++; $display("FAIL spr_to_conn: modes=%b prs=%b want %b/0", modes, bus.prs_clock_frozen, M_CONN);
      end
      do_abort();
   endtask

   task automatic test_iscan_fhs();
      bus.start_iscan = 1;
      tick();
      bus.start_iscan = 0;
      checks++; if (modes !== M_IS || bus.counter_isFHS !== 5'd0) begin
         failures++; $display("FAIL iscan_entry: modes=%b cnt=%0d want %b/0", modes, bus.counter_isFHS, M_IS);
      end
      for (int i = 1; i <= 32; i++) begin
         bus.id_rx_p = 1;
         tick();
         bus.id_rx_p = 0;
         if (i <= 3) begin
            checks++; if (modes !== M_IR) begin failures++; $display("FAIL iscan_to_ir%0d: got %b want %b", i, modes, M_IR); end
         end
         bus.fhs_done_p = 1;
         tick();
         bus.fhs_done_p = 0;
         if (i <= 3 || i >= 31) begin
            checks++;
            if (modes !== M_IS || bus.counter_isFHS !== 5'(i)) begin
               failures++; $display("FAIL isfhs_pair%0d: modes=%b cnt=%0d want %b/%0d", i, modes, bus.counter_isFHS, M_IS, i % 32);
            end
         end
      end
      bus.id_rx_p = 1;
      tick();
      bus.id_rx_p = 0;
      repeat (7) slot();
      bus.m_tslot_p = 1;
      tick();
      bus.m_tslot_p = 0;
      checks++; if (bus.timeout_p !== 1'b1 || modes !== M_IS || bus.counter_isFHS !== 5'd0) begin
         failures++; $display("FAIL ir_timeout: tmo=%b modes=%b cnt=%0d want 1/%b/0", bus.timeout_p, modes, bus.counter_isFHS, M_IS);
      end
      bus.id_rx_p = 1;
      tick();
      bus.id_rx_p = 0;
      bus.fhs_done_p = 1;
      tick();
      bus.fhs_done_p = 0;
      do_abort();
      checks++; if (bus.counter_isFHS !== 5'd1 || modes !== M_NONE) begin
         failures++; $display("FAIL abort_holds_isfhs: cnt=%0d modes=%b want 1/0", bus.counter_isFHS, modes);
      end
      bus.start_iscan = 1;
      tick();
      bus.start_iscan = 0;
      checks++; if (bus.counter_isFHS !== 5'd0) begin failures++; $display("FAIL isfhs_clear_on_entry: got %0d want 0", bus.counter_isFHS); end
      do_abort();
   endtask

   task automatic test_timeout_abort();
      logic seen;
      bus.regi_timeout = 16'd10; bus.regi_Npage = 4'd1;
      bus.start_inquiry = 1;
      tick();
      bus.start_inquiry = 0;
      repeat (3) slot();
      bus.fhs_done_p = 1;
      tick();
      bus.fhs_done_p = 0;
      checks++; if (modes !== M_INQ) begin failures++; $display("FAIL inq_fhs_stays: got %b want %b", modes, M_INQ); end
      repeat (6) slot();
      checks++; if (modes !== M_INQ || bus.timeout_p !== 1'b0) begin
         failures++; $display("FAIL inq_slot9: modes=%b tmo=%b want %b/0", modes, bus.timeout_p, M_INQ);
      end
      bus.m_tslot_p = 1;
      tick();
      bus.m_tslot_p = 0;
      checks++; if (bus.timeout_p !== 1'b1 || modes !== M_NONE || bus.busy !== 1'b0) begin
         failures++; $display("FAIL inq_timeout10: tmo=%b modes=%b busy=%b want 1/0/0", bus.timeout_p, modes, bus.busy);
      end
      tick();
      checks++; if (bus.timeout_p !== 1'b0) begin failures++; $display("FAIL inq_tmo_one_cycle: got %b want 0", bus.timeout_p); end
      bus.start_inquiry = 1;
      tick();
      bus.start_inquiry = 0;
      repeat (3) slot();
      bus.m_tslot_p = 1; bus.abort = 1;
      tick();
      bus.m_tslot_p = 0; bus.abort = 0;
      seen = bus.timeout_p;
      checks++; if (modes !== M_NONE || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_slot4: modes=%b busy=%b want 0/0", modes, bus.busy); end
      repeat (10) begin
         slot();
         seen = seen | bus.timeout_p;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_timeout: saw %b want 0", seen); end
      // Npage of 0 behaves as 1; re-entry from IDLE restores Atrain=1 and clears the switch count.
      bus.regi_timeout = 16'd20; bus.regi_Npage = 4'd0;
      bus.start_inquiry = 1;
      tick();
      bus.start_inquiry = 0;
      repeat (16) slot();
      checks++; if (bus.Atrain !== 1'b0 || bus.pageAB_2Npage_count !== 4'd1) begin
         failures++; $display("FAIL npage0: Atrain=%b cnt=%0d want 0/1", bus.Atrain, bus.pageAB_2Npage_count);
      end
      repeat (4) slot();
      checks++; if (modes !== M_NONE) begin failures++; $display("FAIL inq_timeout20: got %b want 0", modes); end
      bus.start_page = 1;
      tick();
      bus.start_page = 0;
      checks++; if (modes !== M_PAGE || bus.Atrain !== 1'b1 || bus.pageAB_2Npage_count !== 4'd0) begin
         failures++; $display("FAIL page_entry_clear: modes=%b Atrain=%b cnt=%0d want %b/1/0", modes, bus.Atrain, bus.pageAB_2Npage_count, M_PAGE);
      end
      do_abort();
      bus.regi_Npage = 4'd1;
   endtask

   task automatic test_interlace();
      logic [9:0] exp;
      bus.regi_interlace_en = 1; bus.regi_timeout = 16'd40;
      bus.start_pscan = 1;
      tick();
      bus.start_pscan = 0;
      checks++; if (modes !== M_PS) begin failures++; $display("FAIL ilace_slot0: got %b want %b", modes, M_PS); end
      for (int s = 1; s <= 40; s++) begin
         bus.m_tslot_p = 1;
         tick();
         bus.m_tslot_p = 0;
`ifdef HOP_INTERLACE_EN
         exp = (((s / 16) % 2) == 1) ? M_GIPS : M_PS;
`else
         exp = M_PS;
`endif
         if (s == 40) exp = M_NONE;
         checks++;
         if (modes !== exp || bus.timeout_p !== (s == 40)) begin
            failures++; $display("FAIL ilace_slot%0d: modes=%b tmo=%b want %b/%b", s, modes, bus.timeout_p, exp, s == 40);
         end
         tick();
      end
      bus.regi_timeout = 16'd0;
      bus.start_pscan = 1;
      tick();
      bus.start_pscan = 0;
      repeat (16) slot();
      bus.id_rx_p = 1;
      tick();
      bus.id_rx_p = 0;
      checks++; if (modes !== M_SPR) begin failures++; $display("FAIL ilace_response: got %b want %b", modes, M_SPR); end
      do_abort();
      bus.regi_interlace_en = 0;
   endtask

   initial begin
      test_reset();
      test_priority();
      test_train();
      test_page_mpr_conn();
      test_mpr_timeout();
      test_iscan_fhs();
      test_timeout_abort();
      test_interlace();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
